// File: rtl/sbox_perm32.sv
// DES f-function back end: eight S-boxes then the P permutation, one S-box per clock.
// Define SBOXP_PARALLEL_EN to evaluate all eight S-boxes in a single SUB cycle.
module sbox_perm32 #(
  parameter bit P_PERM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SBoxP_Select,
  input  logic [48:1] SBoxP_Input,
  output logic [32:1] SBoxP_Output,
  output logic        SBoxP_Finish_Flag,
  output logic        SBoxP_Busy
);

  typedef enum logic [1:0] {IDLE, SUB, PERM, DONE} state_t;

  // One 64-entry nibble table per S-box, entry index = row*16 + column, entry 0 leftmost.
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
    logic [255:0] tab;
    logic [5:0]   idx;
    int           pos;
    tab = SBOX_TAB[box];
    idx = {grp[5], grp[0], grp[4:1]};
    pos = 255 - 4 * int'(idx);
    return tab[pos -: 4];
  endfunction

  // Vectors are declared [N:1] with DES bit k living at index N+1-k.
  function automatic logic [32:1] p_permute(input logic [32:1] s);
    logic [32:1] r;
    r = '0;
    for (int j = 1; j <= 32; j++) begin
      r[33-j] = s[33-P_TAB[j-1]];
    end
    return r;
  endfunction

  state_t      state_q;
  logic [2:0]  grp_q;
  logic [48:1] din_q;
  logic [32:1] s_q;
  logic [32:1] out_q;
  logic        finish_q;
  logic        busy_q;

`ifdef SBOXP_PARALLEL_EN
  logic [32:1] s_par;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
    assign s_par[32-4*gi -: 4] = sbox_lookup(3'(gi), din_q[48-6*gi -: 6]);
  end
`else
  logic [5:0]  grp_bits;
  logic [3:0]  s_nib;
  logic [32:1] s_d;

  always_comb begin
    grp_bits = din_q[48 - 6*int'(grp_q) -: 6];
    s_nib    = sbox_lookup(grp_q, grp_bits);
    s_d      = s_q;
    s_d[32 - 4*int'(grp_q) -: 4] = s_nib;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grp_q    <= 3'd0;
      din_q    <= '0;
      s_q      <= '0;
      out_q    <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (SBoxP_Select) begin
            din_q   <= SBoxP_Input;
            grp_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
`ifdef SBOXP_PARALLEL_EN
          s_q     <= s_par;
          state_q <= PERM;
`else
          s_q   <= s_d;
          grp_q <= grp_q + 3'd1;
          if (grp_q == 3'd7) begin
            state_q <= PERM;
          end
`endif
        end
        PERM: begin
          out_q    <= P_PERM_EN ? p_permute(s_q) : s_q;
          finish_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SBoxP_Output      = out_q;
  assign SBoxP_Finish_Flag = finish_q;
  assign SBoxP_Busy        = busy_q;

endmodule

// File: tb/tb_sbox_perm32.sv
// Randomised self-checking bench for sbox_perm32; P-permuted and raw instances run side by side.
module tb_sbox_perm32;

`ifdef SBOXP_PARALLEL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 9;
`endif
  localparam int PERIOD_C = LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [48:1] din = '0;
  logic [32:1] out_p, out_r;
  logic        fin_p, fin_r, busy_p, busy_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sbox_perm32 #(.P_PERM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .SBoxP_Select(sel), .SBoxP_Input(din),
    .SBoxP_Output(out_p), .SBoxP_Finish_Flag(fin_p), .SBoxP_Busy(busy_p)
  );

  sbox_perm32 #(.P_PERM_EN(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .SBoxP_Select(sel), .SBoxP_Input(din),
    .SBoxP_Output(out_r), .SBoxP_Finish_Flag(fin_r), .SBoxP_Busy(busy_r)
  );

  // FIPS 46-3 S-boxes, indexed [box][row*16 + column].
  localparam int SBOX_T [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // Reference f-function back end: DES bit k of an n-bit word is numeric bit n-k.
  function automatic logic [31:0] ref_f(input logic [47:0] x, input bit use_p);
    logic [31:0] s, r;
    int b, row, col;
    s = '0;
    for (int g = 0; g < 8; g++) begin
      b   = int'((x >> (42 - 6*g)) & 48'h3F);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      s   = s | (32'(SBOX_T[g][row*16 + col]) << (28 - 4*g));
    end
    if (!use_p) return s;
    r = '0;
    for (int j = 1; j <= 32; j++) r[32-j] = s[32-P_T[j-1]];
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents v with Select for one edge (E0); returns just after E0 with the input scrambled.
  task automatic start(input logic [47:0] v);
    sel = 1'b1;
    din = v;
    tick();
    sel = 1'b0;
    din = rand48();
  endtask

  task automatic test_reset();
    int nfin;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (out_p !== 32'h0 || out_r !== 32'h0) begin
      failures++;
      $display("FAIL reset_output got=%h/%h exp=00000000", out_p, out_r);
    end
    checks++;
    if (fin_p !== 1'b0 || busy_p !== 1'b0 || fin_r !== 1'b0 || busy_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got fin=%b busy=%b exp fin=0 busy=0", fin_p, busy_p);
    end
    nfin = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (fin_p || fin_r || busy_p) nfin++;
    end
    checks++;
    if (nfin != 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d active cycles exp=0", nfin);
    end
  endtask

  task automatic test_known_answer(input logic [47:0] v, input logic [31:0] exp_p,
                                   input logic [31:0] exp_r, input string name);
    int lat, busy_bad;
    lat = 0;
    busy_bad = 0;
    start(v);
    if (busy_p !== 1'b1) busy_bad++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (fin_p) begin
        lat = k;
        break;
      end
      if (busy_p !== 1'b1) busy_bad++;
    end
    $display("txn %s in=%h out=%h raw=%h latency=%0d", name, v, out_p, out_r, lat);
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, lat, LAT);
    end
    checks++;
    if (out_p !== exp_p || out_p !== ref_f(v, 1'b1)) begin
      failures++;
      $display("FAIL %s_out got=%h exp=%h", name, out_p, exp_p);
    end
    checks++;
    if (out_r !== exp_r || fin_r !== 1'b1) begin
      failures++;
      $display("FAIL %s_raw got=%h fin=%b exp=%h fin=1", name, out_r, fin_r, exp_r);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s_busy got=%0d low cycles exp=0", name, busy_bad);
    end
    tick();
    checks++;
    if (fin_p !== 1'b0 || busy_p !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse_end got fin=%b busy=%b exp fin=0 busy=0", name, fin_p, busy_p);
    end
    tick();
    tick();
    checks++;
    if (out_p !== exp_p || out_r !== exp_r) begin
      failures++;
      $display("FAIL %s_hold got=%h/%h exp=%h/%h", name, out_p, out_r, exp_p, exp_r);
    end
  endtask

  task automatic test_random();
    logic [47:0] v;
    int lat;
    for (int n = 0; n < 12; n++) begin
      v = rand48();
      lat = 0;
      start(v);
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (fin_p) begin
          lat = k;
          break;
        end
      end
      $display("txn random%0d in=%h out=%h raw=%h latency=%0d", n, v, out_p, out_r, lat);
      checks++;
      if (lat != LAT || out_p !== ref_f(v, 1'b1) || out_r !== ref_f(v, 1'b0)) begin
        failures++;
        $display("FAIL random%0d got=%h/%h lat=%0d exp=%h/%h lat=%0d", n, out_p, out_r, lat,
                 ref_f(v, 1'b1), ref_f(v, 1'b0), LAT);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_busy_reject();
    logic [47:0] a, b;
    logic [31:0] got;
    int npulse, at_k, lat;
    a = rand48();
    b = rand48();
    npulse = 0;
    at_k = 0;
    got = '0;
    sel = 1'b1;
    din = a;
    tick();
    din = b;
    // Select stays high with B on every busy edge; only the first idle edge may take it.
    for (int k = 1; k < PERIOD_C; k++) begin
      tick();
      if (fin_p) begin
        npulse++;
        at_k = k;
        got = out_p;
      end
    end
    tick();
    sel = 1'b0;
    din = rand48();
    $display("txn busy_reject a=%h b=%h pulses=%0d at=%0d out=%h", a, b, npulse, at_k, got);
    checks++;
    if (npulse != 1 || at_k != LAT) begin
      failures++;
      $display("FAIL busy_pulses got=%0d at %0d exp=1 at %0d", npulse, at_k, LAT);
    end
    checks++;
    if (got !== ref_f(a, 1'b1)) begin
      failures++;
      $display("FAIL busy_result got=%h exp=%h", got, ref_f(a, 1'b1));
    end
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (fin_p) begin
        lat = k;
        break;
      end
    end
    $display("txn busy_accept b=%h out=%h latency=%0d", b, out_p, lat);
    checks++;
    if (lat != LAT || out_p !== ref_f(b, 1'b1)) begin
      failures++;
      $display("FAIL busy_accept got=%h lat=%0d exp=%h lat=%0d", out_p, lat, ref_f(b, 1'b1), LAT);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int nfin;
    start(rand48());
    for (int k = 0; k < ((LAT > 2) ? 4 : 1); k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn reset_mid out=%h fin=%b busy=%b", out_p, fin_p, busy_p);
    checks++;
    if (out_p !== 32'h0 || out_r !== 32'h0 || fin_p !== 1'b0 || busy_p !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got out=%h fin=%b busy=%b exp out=00000000 fin=0 busy=0",
               out_p, fin_p, busy_p);
    end
    nfin = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      if (fin_p || fin_r) nfin++;
    end
    checks++;
    if (nfin != 0) begin
      failures++;
      $display("FAIL reset_mid_no_finish got=%0d pulses exp=0", nfin);
    end
    test_known_answer(48'h6117BA866527, 32'h234AA9BB, 32'h5C82B597, "kat_after_reset");
  endtask

  task automatic test_back_to_back();
    int cnt, accepts;
    int due_q[$];
    logic [31:0] val_q[$];
    logic [31:0] exp_val;
    logic exp_fin;
    cnt = 0;
    accepts = 0;
    for (int t = 0; t < 5*PERIOD_C + LAT + 3; t++) begin
      sel = (t < 5*PERIOD_C);
      din = rand48();
      if (cnt == 0 && sel) begin
        due_q.push_back(t + LAT);
        val_q.push_back(ref_f(din, 1'b1));
        cnt = PERIOD_C - 1;
        accepts++;
      end else if (cnt > 0) begin
        cnt--;
      end
      tick();
      exp_fin = 1'b0;
      exp_val = '0;
      if (due_q.size() > 0 && due_q[0] == t) begin
        exp_fin = 1'b1;
        exp_val = val_q[0];
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end
      checks++;
      if (fin_p !== exp_fin) begin
        failures++;
        $display("FAIL b2b_finish cycle=%0d got=%b exp=%b", t, fin_p, exp_fin);
      end
      if (exp_fin) begin
        $display("txn b2b cycle=%0d out=%h exp=%h", t, out_p, exp_val);
        checks++;
        if (out_p !== exp_val) begin
          failures++;
          $display("FAIL b2b_out cycle=%0d got=%h exp=%h", t, out_p, exp_val);
        end
      end
    end
    sel = 1'b0;
    checks++;
    if (due_q.size() != 0 || accepts != 5) begin
      failures++;
      $display("FAIL b2b_count got pending=%0d accepts=%0d exp pending=0 accepts=5",
               due_q.size(), accepts);
    end
  endtask

  initial begin
    test_reset();
    test_known_answer(48'h6117BA866527, 32'h234AA9BB, 32'h5C82B597, "kat");
    test_known_answer(48'h0, ref_f(48'h0, 1'b1), 32'hEFA72C4D, "zero");
    test_random();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
